// File: rtl/cac_stim_pkg.sv
// rtl/cac_stim_pkg.sv - shared types, constants and helpers for the 3C1S stimulus generator
package cac_stim_pkg;

    typedef enum logic [1:0] {
        MODE_RAND  = 2'd0,
        MODE_WALK1 = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_ZERO  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
    localparam logic [31:0] SEED_STRIDE = 32'h9E37_79B9;
    localparam int          MASK_W      = 256;

    // Low w bits set; callers truncate to their word width.
    function automatic logic [MASK_W-1:0] width_mask(input logic [7:0] w);
        return ~({MASK_W{1'b1}} << w);
    endfunction

    function automatic logic [31:0] lfsr_seed(input logic [31:0] base, input int k);
        logic [31:0] s;
        s = base ^ (32'(k) * SEED_STRIDE);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/cac_lfsr32.sv
// rtl/cac_lfsr32.sv - one 32-bit Galois LFSR word with seed load and step enable
module cac_lfsr32
    import cac_stim_pkg::*;
#(
    parameter logic [31:0] SEED_VAL = 32'h1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic        step,
    output logic [31:0] state_d
);

    logic [31:0] state_q;

    // The next value is exported so the top can build the upcoming vector in the same cycle.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEED_VAL;
        end else if (step) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SEED_VAL;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/cac_stim_gen.sv
// rtl/cac_stim_gen.sv - multi-channel LFSR/walking-one/checkerboard stimulus generator with ucw alignment
module cac_stim_gen
    import cac_stim_pkg::*;
#(
    parameter int          DATA_W  = 124,
    parameter int          ENC_W   = 99,
    parameter int          NUM_CH  = 3,
    parameter int          ENC_LAT = 1,
    parameter int          CNT_W   = 16,
    parameter logic [31:0] SEED    = 32'h1
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic [1:0]                        mode,
    input  logic [CNT_W-1:0]                  num_vectors,
    input  logic [NUM_CH*8-1:0]               ch_width,
    output logic                              busy,
    output logic                              done,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_CH*DATA_W-1:0]          ch_data,
    output logic [NUM_CH*(DATA_W-ENC_W)-1:0]  ucw,
    output logic                              ucw_valid
);

    localparam int NW = (DATA_W + 31) / 32;
    localparam int UW = DATA_W - ENC_W;

    state_e                   state_q, state_d;
    mode_e                    mode_q, mode_d;
    logic [CNT_W-1:0]         num_q, num_d, cnt_q, cnt_d, drain_q, drain_d;
    logic [NUM_CH*8-1:0]      width_q, width_d;
    logic [NUM_CH*DATA_W-1:0] data_q, data_d, vec_d;
    logic                     busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic                     lfsr_load, lfsr_step, vec_load, accept;
    logic [NW*32-1:0]         lfsr_d;
    logic [NUM_CH*UW-1:0]     hi_bits;
    logic [NUM_CH*UW-1:0]     ucw_q [ENC_LAT];
    logic [NUM_CH*UW-1:0]     ucw_d [ENC_LAT];
    logic                     ucwv_q [ENC_LAT];
    logic                     ucwv_d [ENC_LAT];

    assign accept = valid_q & out_ready;

    for (genvar k = 0; k < NW; k++) begin : g_lfsr
        cac_lfsr32 #(.SEED_VAL(lfsr_seed(SEED, k))) u_lfsr (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (lfsr_load),
            .step    (lfsr_step),
            .state_d (lfsr_d[k*32 +: 32])
        );
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        num_d     = num_q;
        width_d   = width_q;
        cnt_d     = cnt_q;
        drain_d   = drain_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        vec_load  = 1'b0;
        case (state_q)
            ST_IDLE: if (start) begin
                mode_d    = mode_e'(mode);
                num_d     = num_vectors;
                width_d   = ch_width;
                cnt_d     = '0;
                lfsr_load = 1'b1;
                if (num_vectors == '0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d  = ST_RUN;
                    vec_load = 1'b1;
                end
            end
            ST_RUN: if (accept) begin
                cnt_d     = cnt_q + CNT_W'(1);
                lfsr_step = 1'b1;
                if (cnt_q == num_q - CNT_W'(1)) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    vec_load = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_q == CNT_W'(ENC_LAT - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d  = (state_d == ST_DONE);
        valid_d = (state_d == ST_RUN);
    end

    // Upcoming vector, built from the post-edge counter, config and LFSR words.
    always_comb begin
        logic [7:0]        w;
        logic [DATA_W-1:0] pat, mask, chk_pat;
        vec_d = '0;
        for (int i = 0; i < DATA_W; i++) begin
            chk_pat[i] = ((i % 2) == 0);
        end
        for (int c = 0; c < NUM_CH; c++) begin
            w = width_d[c*8 +: 8];
            if (32'(w) > DATA_W) begin
                w = 8'(DATA_W);
            end
            mask = DATA_W'(width_mask(w));
            pat  = '0;
            case (mode_d)
                MODE_RAND:  pat = DATA_W'(lfsr_d);
                MODE_WALK1: if (w != 8'd0) pat = DATA_W'(1) << (cnt_d % CNT_W'(w));
                MODE_CHECK: pat = cnt_d[0] ? ~chk_pat : chk_pat;
                default:    pat = '0;
            endcase
            vec_d[c*DATA_W +: DATA_W] = pat & mask;
        end
        data_d = vec_load ? vec_d : data_q;
    end

    always_comb begin
        hi_bits = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hi_bits[c*UW +: UW] = data_q[c*DATA_W + ENC_W +: UW];
        end
    end

    // Free-running delay line matching the encoder register depth.
    always_comb begin
        ucw_d[0]  = hi_bits;
        ucwv_d[0] = accept;
        for (int i = 1; i < ENC_LAT; i++) begin
            ucw_d[i]  = ucw_q[i-1];
            ucwv_d[i] = ucwv_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_RAND;
            num_q   <= '0;
            width_q <= '0;
            cnt_q   <= '0;
            drain_q <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            for (int i = 0; i < ENC_LAT; i++) begin
                ucw_q[i]  <= '0;
                ucwv_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            num_q   <= num_d;
            width_q <= width_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            for (int i = 0; i < ENC_LAT; i++) begin
                ucw_q[i]  <= ucw_d[i];
                ucwv_q[i] <= ucwv_d[i];
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = valid_q;
    assign ch_data   = data_q;
    assign ucw       = ucw_q[ENC_LAT-1];
    assign ucw_valid = ucwv_q[ENC_LAT-1];

endmodule

// File: tb/tb_cac_stim_gen.sv
// tb/tb_cac_stim_gen.sv - randomized self-checking bench with a behavioural vector model
module tb_cac_stim_gen;

    localparam int          DATA_W  = 124;
    localparam int          ENC_W   = 99;
    localparam int          NUM_CH  = 3;
    localparam int          ENC_LAT = 1;
    localparam int          CNT_W   = 16;
    localparam logic [31:0] SEED    = 32'h1;
    localparam int          NW      = 4;
    localparam int          UW      = DATA_W - ENC_W;
    localparam int          VW      = NUM_CH * DATA_W;

    logic                   clock, reset_n, start, out_ready;
    logic [1:0]             mode;
    logic [CNT_W-1:0]       num_vectors;
    logic [NUM_CH*8-1:0]    ch_width;
    logic                   busy, done, out_valid, ucw_valid;
    logic [VW-1:0]          ch_data;
    logic [NUM_CH*UW-1:0]   ucw;

    cac_stim_gen #(
        .DATA_W(DATA_W), .ENC_W(ENC_W), .NUM_CH(NUM_CH),
        .ENC_LAT(ENC_LAT), .CNT_W(CNT_W), .SEED(SEED)
    ) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
        .num_vectors(num_vectors), .ch_width(ch_width), .busy(busy), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .ch_data(ch_data),
        .ucw(ucw), .ucw_valid(ucw_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Model state: what the outputs must be in the current cycle.
    bit             exp_busy, exp_done, exp_valid;
    int             m_idx, m_n, done_at, cyc;
    logic [1:0]     m_mode;
    logic [23:0]    m_w;
    logic [31:0]    m_lfsr [NW];
    bit             hist_v [64];
    logic [VW-1:0]  hist_d [64];
    int             acc_cnt, ucw_cnt, done_cyc, last_acc_cyc, start_cyc;
    bit             done_seen, valid_seen, prev_stall;
    logic [VW-1:0]  prev_data;
    logic [VW-1:0]  cap [$];

    function automatic logic [31:0] galois(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    task automatic reseed();
        logic [31:0] s;
        for (int k = 0; k < NW; k++) begin
            s = SEED ^ (32'(k) * 32'h9E37_79B9);
            m_lfsr[k] = (s == 32'h0) ? 32'h1 : s;
        end
    endtask

    function automatic logic [VW-1:0] model_vec();
        logic [VW-1:0] v;
        int  wc;
        bit  b_on;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wc = int'(m_w[c*8 +: 8]);
            if (wc > DATA_W) wc = DATA_W;
            for (int b = 0; b < wc; b++) begin
                case (m_mode)
                    2'd0:    b_on = m_lfsr[b/32][b%32];
                    2'd1:    b_on = (b == (m_idx % wc));
                    2'd2:    b_on = ((b % 2) == 0) != ((m_idx % 2) == 1);
                    default: b_on = 1'b0;
                endcase
                v[c*DATA_W + b] = b_on;
            end
        end
        return v;
    endfunction

    function automatic logic [NUM_CH*UW-1:0] hi_of(input logic [VW-1:0] v);
        logic [NUM_CH*UW-1:0] h;
        for (int c = 0; c < NUM_CH; c++) h[c*UW +: UW] = v[c*DATA_W + ENC_W +: UW];
        return h;
    endfunction

    always @(negedge clock) begin
        logic [VW-1:0] v;
        bit acc;
        int hi;
        cyc++;
        if (!reset_n) begin
            exp_busy = 0; exp_done = 0; exp_valid = 0; prev_stall = 0;
            for (int i = 0; i < 64; i++) hist_v[i] = 0;
        end else begin
            v = model_vec();
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("out_valid", out_valid, exp_valid);
            if (exp_valid) chk("ch_data", ch_data, v);
            if (prev_stall) chk("hold", ch_data, prev_data);
            hi = (cyc - ENC_LAT) & 63;
            chk("ucw_valid", ucw_valid, hist_v[hi]);
            if (hist_v[hi]) chk("ucw", ucw, hi_of(hist_d[hi]));
            if (out_valid && out_ready) begin
                acc_cnt++;
                cap.push_back(ch_data);
                last_acc_cyc = cyc;
            end
            if (ucw_valid) ucw_cnt++;
            if (done) begin done_seen = 1; done_cyc = cyc; end
            if (out_valid) valid_seen = 1;
            acc = exp_valid && out_ready;
            hist_v[cyc & 63] = acc;
            hist_d[cyc & 63] = v;
            prev_stall = out_valid && !out_ready;
            prev_data  = ch_data;
            if (exp_done) begin
                exp_done = 0;
            end else if (!exp_busy) begin
                if (start) begin
                    m_mode = mode; m_n = int'(num_vectors); m_w = ch_width;
                    reseed();
                    m_idx = 0;
                    start_cyc = cyc;
                    if (m_n == 0) exp_done = 1;
                    else begin exp_valid = 1; exp_busy = 1; end
                end
            end else begin
                if (acc) begin
                    for (int k = 0; k < NW; k++) m_lfsr[k] = galois(m_lfsr[k]);
                    m_idx++;
                    if (m_idx == m_n) begin
                        exp_valid = 0;
                        done_at   = cyc + ENC_LAT + 1;
                    end
                end
                if (!exp_valid && (cyc + 1 == done_at)) begin
                    exp_done = 1; exp_busy = 0;
                end
            end
        end
    end

    int rpol, rph;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_ready();
        case (rpol)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: begin out_ready = ((rph % 4) == 0) || ((rph % 4) == 3); rph++; end
        endcase
    endtask

    task automatic do_run(input logic [1:0] md, input int n, input logic [23:0] w,
                          input int pol, input int abort_at, input int poke_at);
        acc_cnt = 0; ucw_cnt = 0; done_seen = 0; valid_seen = 0;
        done_cyc = -1; last_acc_cyc = -1;
        cap.delete();
        rpol = pol; rph = 0;
        mode = md; num_vectors = CNT_W'(n); ch_width = w; start = 1'b1;
        set_ready();
        tick();
        start = 1'b0;
        for (int i = 0; i < 400 && !done_seen; i++) begin
            if (abort_at >= 0 && acc_cnt == abort_at) break;
            start = (i == poke_at);
            if (start) begin mode = 2'd3; num_vectors = CNT_W'(2); end
            set_ready();
            tick();
        end
        start = 1'b0;
        if (abort_at < 0) begin
            chk("run_timeout", done_seen, 1);
            tick();
            tick();
        end else begin
            chk("abort_reach", acc_cnt, abort_at);
        end
    endtask

    logic [VW-1:0] cap_a [$];
    logic [VW-1:0] v0;
    int            w1 [5] = '{1, 2, 4, 8, 16};
    int            rn;

    initial begin
        reset_n = 1'b0; start = 1'b0; mode = 2'd0; num_vectors = '0;
        ch_width = '0; out_ready = 1'b0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_ucw_valid", ucw_valid, 0);
        chk("rst_ch_data", ch_data, 0);
        chk("rst_ucw", ucw, 0);
        @(posedge clock); #1 reset_n = 1'b1;
        tick();

        do_run(2'd1, 5, {8'd124, 8'd111, 8'd99}, 0, -1, -1);
        chk("walk_cnt", cap.size(), 5);
        for (int k = 0; k < 5 && k < cap.size(); k++) chk("walk_ch0", cap[k][DATA_W-1:0], w1[k]);
        chk("walk_done_lat", done_cyc - last_acc_cyc, 2);

        do_run(2'd2, 2, {8'd99, 8'd111, 8'd124}, 0, -1, -1);
        chk("check_cnt", cap.size(), 2);
        if (cap.size() == 2) begin
            chk("check_v0_ch2", cap[0][2*DATA_W +: DATA_W], 124'h5_5555_5555_5555_5555_5555_5555);
            chk("check_v1_ch2", cap[1][2*DATA_W +: DATA_W], 124'h2_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
        end

        do_run(2'd0, 8, {3{8'd124}}, 1, -1, -1);
        cap_a = cap;
        do_run(2'd0, 8, {3{8'd124}}, 1, -1, -1);
        chk("rand_cnt", cap.size(), cap_a.size());
        for (int k = 0; k < cap.size() && k < cap_a.size(); k++) chk("rand_repeat", cap[k], cap_a[k]);
        if (cap_a.size() >= 2) begin
            chk("rand_v0_w0", cap_a[0][31:0], 32'h1);
            chk("rand_v0_w1", cap_a[0][63:32], 32'h9E37_79B8);
            chk("rand_v1_w0", cap_a[1][31:0], 32'h8020_0003);
        end

        do_run(2'd2, 6, {8'd0, 8'd50, 8'd124}, 2, -1, -1);
        chk("stall_accepts", acc_cnt, 6);
        chk("stall_ucw_pulses", ucw_cnt, 6);

        do_run(2'd1, 0, {3{8'd124}}, 0, -1, -1);
        chk("zero_no_valid", valid_seen, 0);
        chk("zero_done_lat", done_cyc - start_cyc, 1);
        do_run(2'd1, 10, {8'd124, 8'd7, 8'd200}, 0, -1, 3);
        chk("poke_accepts", acc_cnt, 10);

        do_run(2'd0, 10, {3{8'd124}}, 0, 3, -1);
        v0 = (cap.size() > 0) ? cap[0] : '0;
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ucw_valid", ucw_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ch_data", ch_data, 0);
        chk("mid_rst_ucw", ucw, 0);
        @(posedge clock); #1 reset_n = 1'b1;
        tick();
        do_run(2'd0, 4, {3{8'd124}}, 0, -1, -1);
        chk("reset_repeat_v0", (cap.size() > 0) ? cap[0] : '0, v0);

        for (int r = 0; r < 6; r++) begin
            rn = $urandom_range(1, 12);
            do_run(2'($urandom_range(0, 3)), rn,
                   {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))},
                   1, -1, -1);
            chk("rand_run_accepts", acc_cnt, rn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
